// File: rtl/fpu_q_pkg.sv
// fpu_q_pkg: shared op/state types, Q16.48 constants and sign helpers
// for the fixed-point ALU and its divider.
package fpu_q_pkg;
    localparam int          Q_FRAC_BITS = 48;
    localparam logic [63:0] Q_ONE       = 64'h0001_0000_0000_0000;
    localparam logic [63:0] Q_MAX       = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] Q_MIN       = 64'h8000_0000_0000_0000;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

    // Q_MIN maps to the unsigned magnitude 2^63 without wrapping.
    function automatic logic [63:0] q_abs(input logic [63:0] x);
        return x[63] ? -x : x;
    endfunction

    function automatic logic [63:0] q_signed(input logic [63:0] mag, input logic neg);
        return neg ? -mag : mag;
    endfunction

    function automatic logic [63:0] q_sat(input logic neg);
        return neg ? Q_MIN : Q_MAX;
    endfunction
endpackage

// File: rtl/fpu_q_alu_if.sv
// fpu_q_alu_if: operand/result handshake bundle between the FPU input mux
// (master) and the Q16.48 ALU (slave).
interface fpu_q_alu_if;
    import fpu_q_pkg::*;
    logic        in_valid;
    logic        in_ready;
    op_e         op;
    logic [63:0] a_data;
    logic [63:0] b_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_ovf;
    logic        out_dz;

    modport master (
        output in_valid, op, a_data, b_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_dz
    );
    modport slave (
        input  in_valid, op, a_data, b_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_dz
    );
endinterface

// File: rtl/q_mag_divider.sv
// q_mag_divider: unsigned restoring divider, one quotient bit per cycle,
// 112 cycles per 112-bit dividend over a 64-bit divisor.
module q_mag_divider (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         abort,
    input  logic [111:0] dividend,
    input  logic [63:0]  divisor,
    output logic         busy,
    output logic         done,
    output logic [111:0] quotient
);
    logic [111:0] dq_q, dq_d;
    logic [63:0]  rem_q, rem_d, dvs_q, dvs_d;
    logic [6:0]   cnt_q, cnt_d;
    logic         busy_q, busy_d;
    logic [64:0]  trial;

    // dq_q shifts dividend bits out the top while quotient bits enter the bottom.
    assign trial    = {rem_q, dq_q[111]} - {1'b0, dvs_q};
    assign busy     = busy_q;
    assign done     = busy_q && cnt_q == 7'd111;
    assign quotient = {dq_q[110:0], ~trial[64]};

    always_comb begin
        dq_d   = dq_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (abort) begin
            busy_d = 1'b0;
        end else if (start) begin
            dq_d   = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d  = trial[64] ? {rem_q[62:0], dq_q[111]} : trial[63:0];
            dq_d   = quotient;
            cnt_d  = cnt_q + 7'd1;
            busy_d = !done;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dq_q   <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            dq_q   <= dq_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end
endmodule

// File: rtl/fpu_q_alu.sv
// fpu_q_alu: signed Q16.48 add/sub/mul/div with saturation, one operation
// in flight, valid/ready handshake on both sides and synchronous flush.
module fpu_q_alu
    import fpu_q_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    fpu_q_alu_if.slave bus
);
    state_e        state_q, state_d;
    logic [63:0]   ma_q, ma_d, mb_q, mb_d, out_data_q, out_data_d;
    logic [127:0]  acc_q, acc_d, acc_nx;
    logic [1:0]    cnt_q, cnt_d;
    logic          neg_q, neg_d, ovf_q, ovf_d, dz_q, dz_d;
    logic          accept, add_ovf, mul_ovf, div_ovf, div_start, div_busy, div_done;
    logic [63:0]   abs_a, abs_b;
    logic [64:0]   sum;
    logic [79:0]   partial;
    logic [111:0]  quotient;

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_dz    = dz_q;

    assign accept    = bus.in_valid && bus.in_ready && !bus.flush;
    assign abs_a     = q_abs(bus.a_data);
    assign abs_b     = q_abs(bus.b_data);
    assign div_start = accept && bus.op == OP_DIV && bus.b_data != '0;
    assign sum       = bus.op == OP_SUB ? {bus.a_data[63], bus.a_data} - {bus.b_data[63], bus.b_data}
                                        : {bus.a_data[63], bus.a_data} + {bus.b_data[63], bus.b_data};
    assign add_ovf   = sum[64] ^ sum[63];

    // One 16-bit slice of |b| per MUL cycle, shifted into place in the 128-bit product.
    assign partial = ma_q * mb_q[{cnt_q, 4'b0000} +: 16];
    assign acc_nx  = acc_q + ({48'b0, partial} << {cnt_q, 4'b0000});
    assign mul_ovf = |acc_nx[127:111];
    assign div_ovf = |quotient[111:64] || (neg_q ? quotient[63] && |quotient[62:0] : quotient[63]);

    q_mag_divider u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .abort    (bus.flush),
        .dividend ({abs_a, {Q_FRAC_BITS{1'b0}}}),
        .divisor  (abs_b),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    always_comb begin
        state_d    = state_q;
        ma_d       = ma_q;
        mb_d       = mb_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        out_data_d = out_data_q;
        ovf_d      = ovf_q;
        dz_d       = dz_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    neg_d = bus.a_data[63] ^ bus.b_data[63];
                    ma_d  = abs_a;
                    mb_d  = abs_b;
                    acc_d = '0;
                    cnt_d = '0;
                    case (bus.op)
                        OP_ADD, OP_SUB: begin
                            out_data_d = add_ovf ? q_sat(sum[64]) : sum[63:0];
                            ovf_d      = add_ovf;
                            dz_d       = 1'b0;
                            state_d    = DONE;
                        end
                        OP_MUL: state_d = MUL;
                        OP_DIV: if (bus.b_data == '0) begin
                            out_data_d = q_sat(bus.a_data[63]);
                            ovf_d      = 1'b0;
                            dz_d       = 1'b1;
                            state_d    = DONE;
                        end else begin
                            state_d = DIV;
                        end
                    endcase
                end
                MUL: begin
                    acc_d = acc_nx;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        out_data_d = mul_ovf ? q_sat(neg_q) : q_signed(acc_nx[111:Q_FRAC_BITS], neg_q);
                        ovf_d      = mul_ovf;
                        dz_d       = 1'b0;
                        state_d    = DONE;
                    end
                end
                DIV: if (div_done) begin
                    out_data_d = div_ovf ? q_sat(neg_q) : q_signed(quotient[63:0], neg_q);
                    ovf_d      = div_ovf;
                    dz_d       = 1'b0;
                    state_d    = DONE;
                end else if (!div_busy) begin
                    state_d = IDLE;
                end
                DONE: if (bus.out_ready) state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ma_q       <= '0;
            mb_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            out_data_q <= '0;
            ovf_q      <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ma_q       <= ma_d;
            mb_q       <= mb_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            out_data_q <= out_data_d;
            ovf_q      <= ovf_d;
            dz_q       <= dz_d;
        end
    end
endmodule

// File: tb/tb_fpu_q_alu.sv
// tb_fpu_q_alu: directed and random operations against a wide signed-integer
// reference model, plus latency, back-pressure, reset and flush scenarios.
module tb_fpu_q_alu;
    import fpu_q_pkg::*;

    localparam logic signed [127:0] ONE_W  = 128'sd1 <<< 48;
    localparam logic signed [127:0] BIG_W  = 128'sd1 <<< 111;
    localparam logic signed [127:0] QMAX_W = (128'sd1 <<< 63) - 128'sd1;
    localparam logic signed [127:0] QMIN_W = -(128'sd1 <<< 63);

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fails  = 0;

    fpu_q_alu_if bus();
    fpu_q_alu dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Real-valued Q16.48 semantics evaluated on 128-bit signed integers.
    function automatic void model(input op_e o, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic ovf, output logic dz);
        logic signed [127:0] sa, sb, p, x;
        sa = 128'($signed(a));
        sb = 128'($signed(b));
        dz = 1'b0;
        case (o)
            OP_ADD: x = sa + sb;
            OP_SUB: x = sa - sb;
            OP_MUL: begin
                p = sa * sb;
                x = (p >= BIG_W || p <= -BIG_W) ? (p < 0 ? QMIN_W - 1 : QMAX_W + 1) : p / ONE_W;
            end
            default: if (b == '0) begin
                dz = 1'b1;
                x  = sa < 0 ? QMIN_W : QMAX_W;
            end else begin
                x = (sa * ONE_W) / sb;
            end
        endcase
        ovf = x > QMAX_W || x < QMIN_W;
        r   = ovf ? (x < 0 ? Q_MIN : Q_MAX) : x[63:0];
    endfunction

    task automatic run_op(input string tag, input op_e o, input logic [63:0] a,
                          input logic [63:0] b, input int stall);
        logic [63:0] er;
        logic        eo, ed;
        int          lat, exp_lat;
        model(o, a, b, er, eo, ed);
        exp_lat = (o == OP_MUL) ? 5 : (o == OP_DIV && b != '0) ? 113 : 1;
        @(negedge clk);
        check({tag, " in_ready idle"}, 64'(bus.in_ready), 64'd1);
        bus.op       = o;
        bus.a_data   = a;
        bus.b_data   = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        if (!bus.out_valid) begin
            bus.flush = 1'b1;
            @(negedge clk);
            bus.flush = 1'b0;
        end else begin
            check({tag, " data"}, bus.out_data, er);
            check({tag, " ovf"}, 64'(bus.out_ovf), 64'(eo));
            check({tag, " dz"}, 64'(bus.out_dz), 64'(ed));
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check({tag, " hold data"}, bus.out_data, er);
                check({tag, " hold valid"}, 64'(bus.out_valid), 64'd1);
                check({tag, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            check({tag, " valid after take"}, 64'(bus.out_valid), 64'd0);
            check({tag, " in_ready after take"}, 64'(bus.in_ready), 64'd1);
        end
    endtask

    function automatic logic [63:0] rnd_q();
        logic signed [63:0] v;
        v = $signed({$urandom, $urandom});
        return v >>> $urandom_range(0, 62);
    endfunction

    initial begin
        logic seen;
        logic [63:0] b;
        op_e o;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = OP_ADD;
        bus.a_data    = '0;
        bus.b_data    = '0;
        reset_n       = 1'b0;
        #1;
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset out_data", bus.out_data, 64'd0);
        check("reset flags", {62'd0, bus.out_ovf, bus.out_dz}, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("in_ready after reset", 64'(bus.in_ready), 64'd1);

        run_op("mul 1.5x2", OP_MUL, 64'h0001_8000_0000_0000, 64'h0002_0000_0000_0000, 0);
        run_op("div 1/-4", OP_DIV, Q_ONE, 64'hFFFC_0000_0000_0000, 0);
        run_op("div 1/0", OP_DIV, Q_ONE, 64'd0, 0);
        run_op("add sat max", OP_ADD, 64'h7FFF_0000_0000_0000, Q_ONE, 3);
        run_op("div min/1", OP_DIV, Q_MIN, Q_ONE, 0);
        run_op("sub 0-min", OP_SUB, 64'd0, Q_MIN, 0);
        run_op("add sat min", OP_ADD, Q_MIN, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("div neg/0", OP_DIV, 64'hFFFF_8000_0000_0000, 64'd0, 0);
        run_op("mul -1.5x2", OP_MUL, 64'hFFFE_8000_0000_0000, 64'h0002_0000_0000_0000, 1);
        run_op("div max/small", OP_DIV, Q_MAX, 64'h0000_0000_0001_0000, 0);
        run_op("mul sat", OP_MUL, 64'h0100_0000_0000_0000, 64'hFF00_0000_0000_0000, 0);

        // Reset in the middle of a division: result is lost.
        @(negedge clk);
        bus.op = OP_DIV; bus.a_data = Q_ONE; bus.b_data = 64'h0003_0000_0000_0000; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (49) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid-div reset out_valid", 64'(bus.out_valid), 64'd0);
        check("mid-div reset out_data", bus.out_data, 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("in_ready after mid-div reset", 64'(bus.in_ready), 64'd1);
        seen = 1'b0;
        repeat (150) begin
            @(negedge clk);
            seen |= bus.out_valid;
        end
        check("no result after reset", 64'(seen), 64'd0);

        // Flush two cycles into a multiply.
        bus.op = OP_MUL; bus.a_data = Q_ONE; bus.b_data = Q_ONE; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush mul in_ready", 64'(bus.in_ready), 64'd1);
        seen = bus.out_valid;
        repeat (10) begin
            @(negedge clk);
            seen |= bus.out_valid;
        end
        check("flush mul no valid", 64'(seen), 64'd0);
        check("flush mul data kept", bus.out_data, 64'd0);

        // Flush outranks a simultaneous operand offer.
        bus.op = OP_ADD; bus.a_data = Q_ONE; bus.b_data = Q_ONE; bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        check("flush beats in_valid", 64'(bus.out_valid), 64'd0);

        for (int i = 0; i < 30; i++) begin
            o = op_e'($urandom_range(0, 3));
            b = (o == OP_DIV && $urandom_range(0, 7) == 0) ? 64'd0 : rnd_q();
            run_op($sformatf("rand%0d op%0d", i, o), o, rnd_q(), b, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
